pattern_detect_ctrl: RTL and testbench

//  Run-time programmable serial bit-pattern detector with control sequencing.

---
 rtl/pattern_detect_pkg.sv | 29 ++
 rtl/pattern_detect_ctrl_matcher.sv | 60 ++++++
 rtl/pattern_detect_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pattern_detect_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_detect_pkg.sv
// Shared definitions for the programmable pattern detector.
// Contents:
//   state_t    FSM state encoding (IDLE / RUN / DONE)
//   LEN_W      width of a length field for the default 8-bit pattern
//   clamp_len  maps a written length onto the legal range 1..max_len
package pattern_detect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_LEN_DEFAULT = 8;
  localparam int LEN_W = $clog2(MAX_LEN_DEFAULT) + 1;

  // A zero length would never match, and a length beyond the shift register
  // cannot be compared, so both ends are pulled into range.
  function automatic int clamp_len(input int len, input int max_len);
    if (len == 0) begin
      return 1;
    end
    if (len > max_len) begin
      return max_len;
    end
    return len;
  endfunction

endpackage

// File: rtl/pattern_detect_ctrl_matcher.sv
// pattern_matcher: shift register, fill counter and masked pattern compare.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   shift_en    accepted beat: shift bit_in into the register
//   clear       start of a run: empty the register and fill count
//   bit_in      serial data bit
//   len         active pattern length (1..MAX_LEN)
//   pattern     pattern, bit0 = most recent bit
//   overlap     1 = keep history after a match
//   hit         combinational: the shift happening this cycle completes a match
module pattern_matcher #(
  parameter int MAX_LEN = 8,
  parameter int LW      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_en,
  input  logic               clear,
  input  logic               bit_in,
  input  logic [LW-1:0]      len,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic               overlap,
  output logic               hit
);

  logic [MAX_LEN-1:0] shreg;
  logic [MAX_LEN-1:0] shreg_nxt;
  logic [MAX_LEN-1:0] mask;
  logic [LW-1:0]      fill;
  logic [LW:0]        fill_inc;
  logic               full;

  always_comb begin
    shreg_nxt = {shreg[MAX_LEN-2:0], bit_in};
    // len == MAX_LEN shifts every one out, giving an all-ones mask.
    mask      = ~({MAX_LEN{1'b1}} << len);
    fill_inc  = {1'b0, fill} + (LW+1)'(1);
    full      = (fill_inc >= {1'b0, len});
    hit       = shift_en && full && ((shreg_nxt & mask) == (pattern & mask));
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shreg <= '0;
      fill  <= '0;
    end else if (shift_en) begin
      shreg <= shreg_nxt;
      // Without overlap the history is forgotten, so the next match
      // needs len fresh bits.
      if (hit && !overlap) begin
        fill <= '0;
      end else if (full) begin
        fill <= len;
      end else begin
        fill <= fill_inc[LW-1:0];
      end
    end
  end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// pattern_detect_ctrl: run-time programmable serial pattern detector.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   cfg_we           config write (ignored while running)
//   cfg_pattern      pattern, bit0 = last bit received
//   cfg_len          pattern length, clamped to 1..MAX_LEN
//   cfg_overlap      1 = overlapping matches allowed
//   cfg_threshold    matches until done, 0 = free-run
//   start / stop     arm or restart / abort to IDLE (stop wins)
//   bit_valid/bit_in serial input, accepted when bit_valid & bit_ready
//   bit_ready        registered, high while running
//   match            one-cycle pulse per match
//   match_count      saturating match count
//   busy             running
//   done             threshold reached, held until start or reset
//
// state | meaning
// IDLE  | waiting for start, config writable
// RUN   | accepting beats and counting matches
// DONE  | threshold reached, config writable, waiting for start
module pattern_detect_ctrl
  import pattern_detect_pkg::*;
#(
  parameter int                 MAX_LEN   = 8,
  parameter int                 CNT_W     = 8,
  parameter logic [MAX_LEN-1:0] PAT_RESET = MAX_LEN'(3'b110),
  parameter int                 LEN_RESET = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [MAX_LEN-1:0]       cfg_pattern,
  input  logic [$clog2(MAX_LEN):0] cfg_len,
  input  logic                     cfg_overlap,
  input  logic [CNT_W-1:0]         cfg_threshold,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     bit_valid,
  input  logic                     bit_in,
  output logic                     bit_ready,
  output logic                     match,
  output logic [CNT_W-1:0]         match_count,
  output logic                     busy,
  output logic                     done
);

  localparam int LW = $clog2(MAX_LEN) + 1;

  state_t             state;
  state_t             state_nxt;

  logic [MAX_LEN-1:0] pat_q;
  logic [LW-1:0]      len_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   thr_q;

  logic               accept;
  logic               run_clear;
  logic               shift_en;
  logic               hit;
  logic               thr_hit;
  logic [CNT_W-1:0]   cnt_inc;

  logic               match_nxt;
  logic [CNT_W-1:0]   count_nxt;
  logic               busy_nxt;
  logic               ready_nxt;
  logic               done_nxt;

  always_comb begin
    accept    = bit_valid && bit_ready && (state == RUN);
    run_clear = start && !stop;
    // A beat landing together with start or stop is dropped.
    shift_en  = accept && !start && !stop;
    cnt_inc   = (&match_count) ? match_count : match_count + CNT_W'(1);
    thr_hit   = hit && (thr_q != '0) && (cnt_inc == thr_q);
  end

  pattern_matcher #(
    .MAX_LEN (MAX_LEN),
    .LW      (LW)
  ) u_matcher (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .clear    (run_clear),
    .bit_in   (bit_in),
    .len      (len_q),
    .pattern  (pat_q),
    .overlap  (ovl_q),
    .hit      (hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (run_clear) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (thr_hit) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    match_nxt = hit;
    count_nxt = match_count;
    if (run_clear) begin
      count_nxt = '0;
    end else if (hit) begin
      count_nxt = cnt_inc;
    end
    busy_nxt  = (state_nxt == RUN);
    ready_nxt = (state_nxt == RUN);
    done_nxt  = done;
    if (run_clear) begin
      done_nxt = 1'b0;
    end else if (thr_hit) begin
      done_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      match       <= 1'b0;
      match_count <= '0;
      busy        <= 1'b0;
      bit_ready   <= 1'b0;
      done        <= 1'b0;
    end else begin
      match       <= match_nxt;
      match_count <= count_nxt;
      busy        <= busy_nxt;
      bit_ready   <= ready_nxt;
      done        <= done_nxt;
    end
  end

  // Writes landing with a start from IDLE/DONE take effect before the run.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q <= PAT_RESET;
      len_q <= LW'(LEN_RESET);
      ovl_q <= 1'b1;
      thr_q <= CNT_W'(1);
    end else if (cfg_we && (state != RUN)) begin
      pat_q <= cfg_pattern;
      len_q <= LW'(clamp_len(int'(cfg_len), MAX_LEN));
      ovl_q <= cfg_overlap;
      thr_q <= cfg_threshold;
    end
  end

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
module tb_pattern_detect_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_threshold;
  logic       start, stop, bit_valid, bit_in;

  logic       bit_ready, match, busy, done;
  logic [7:0] match_count;
  logic       bit_ready4, match4, busy4, done4;
  logic [3:0] match_count4;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  int   m_mode;   // 0 idle, 1 run, 2 done
  logic [7:0] m_pat;
  int   m_len;
  bit   m_ovl;
  int   m_thr;
  int   m_cnt;
  bit   m_match, m_busy, m_ready, m_done;
  bit   hist[$];

  always #5 clk = ~clk;

  pattern_detect_ctrl dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_threshold(cfg_threshold),
    .start(start), .stop(stop), .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_ready(bit_ready), .match(match), .match_count(match_count),
    .busy(busy), .done(done)
  );

  pattern_detect_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_threshold(cfg_threshold[3:0]),
    .start(start), .stop(stop), .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_ready(bit_ready4), .match(match4), .match_count(match_count4),
    .busy(busy4), .done(done4)
  );

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit tail_matches();
    for (int k = 0; k < m_len; k++) begin
      if (m_pat[k] != hist[hist.size()-1-k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit run_before, acc;
    if (reset) begin
      m_mode = 0; hist.delete(); m_cnt = 0;
      m_match = 0; m_busy = 0; m_ready = 0; m_done = 0;
      m_pat = 8'b110; m_len = 3; m_ovl = 1; m_thr = 1;
      return;
    end
    run_before = (m_mode == 1);
    acc = run_before && bit_valid && m_ready;
    m_match = 0;
    if (cfg_we && !run_before) begin
      m_pat = cfg_pattern;
      m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > 8) ? 8 : int'(cfg_len));
      m_ovl = cfg_overlap;
      m_thr = int'(cfg_threshold);
    end
    if (stop) begin
      if (run_before) begin
        m_mode = 0; m_busy = 0; m_ready = 0;
      end
    end else if (start) begin
      m_mode = 1; hist.delete(); m_cnt = 0; m_done = 0; m_busy = 1; m_ready = 1;
    end else if (acc) begin
      hist.push_back(bit_in);
      if (hist.size() >= m_len && tail_matches()) begin
        m_match = 1;
        m_cnt++;
        if (!m_ovl) hist.delete();
        if (m_thr != 0 && sat(m_cnt, 255) == m_thr) begin
          m_mode = 2; m_done = 1; m_busy = 0; m_ready = 0;
        end
      end
      if (hist.size() > 16) void'(hist.pop_front());
    end
  endtask

  task automatic check_all();
    chk("match",     32'(match),        32'(m_match));
    chk("count",     32'(match_count),  32'(sat(m_cnt, 255)));
    chk("busy",      32'(busy),         32'(m_busy));
    chk("bit_ready", 32'(bit_ready),    32'(m_ready));
    chk("done",      32'(done),         32'(m_done));
    chk("match4",    32'(match4),       32'(m_match));
    chk("count4",    32'(match_count4), 32'(sat(m_cnt, 15)));
    chk("busy4",     32'(busy4),        32'(m_busy));
    chk("ready4",    32'(bit_ready4),   32'(m_ready));
    chk("done4",     32'(done4),        32'(m_done));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send(input bit b, input bit gaps);
    int g;
    g = gaps ? $urandom_range(0, 3) : 0;
    repeat (g) begin
      bit_valid = 0; bit_in = 1'($urandom_range(0, 1)); tick();
    end
    bit_valid = 1; bit_in = b; tick();
    bit_valid = 0; bit_in = 1'($urandom_range(0, 1));
  endtask

  task automatic send_stream(input logic [15:0] s, input int n, input bit gaps);
    logic [15:0] v;
    v = s;
    for (int i = n - 1; i >= 0; i--) send(v[i], gaps);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input bit o, input logic [7:0] t);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_threshold = t;
    cfg_we = 1; tick(); cfg_we = 0;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic pulse_stop();
    stop = 1; tick(); stop = 0;
  endtask

  initial begin
    reset = 1; cfg_we = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
    cfg_threshold = 0; start = 0; stop = 0; bit_valid = 0; bit_in = 0;
    tick(); tick();
    reset = 0;
    tick();
    chk("rst_count", 32'(match_count), 0);
    chk("rst_ready", 32'(bit_ready), 0);

    // Defaults: pattern 110, len 3, threshold 1
    pulse_start();
    send_stream(16'b110, 3, 0);
    chk("t1_match", 32'(match), 1);
    chk("t1_count", 32'(match_count), 1);
    chk("t1_done",  32'(done), 1);
    chk("t1_ready", 32'(bit_ready), 0);
    send(1, 0);
    tick();

    // Overlap vs non-overlap
    cfg(8'b1010, 4, 1, 0);
    pulse_start();
    send_stream(16'b10101010, 8, 0);
    tick();
    chk("t2_ovl_count", 32'(match_count), 3);
    pulse_stop();
    cfg(8'b1010, 4, 0, 0);
    pulse_start();
    send_stream(16'b10101010, 8, 0);
    tick();
    chk("t2_novl_count", 32'(match_count), 2);
    pulse_stop();

    // Gapped stream on defaults
    cfg(8'b110, 3, 1, 1);
    pulse_start();
    send_stream(16'b110, 3, 1);
    chk("t3_count", 32'(match_count), 1);
    chk("t3_done",  32'(done), 1);

    // stop holds count, beat in stop cycle dropped, start clears
    cfg(8'b110, 3, 1, 0);
    pulse_start();
    send_stream(16'b1101, 4, 0);
    stop = 1; bit_valid = 1; bit_in = 0; tick(); stop = 0; bit_valid = 0;
    chk("t4_held", 32'(match_count), 1);
    chk("t4_busy", 32'(busy), 0);
    send_stream(16'b110, 3, 0);
    chk("t4_idle_count", 32'(match_count), 1);
    pulse_start();
    chk("t4_cleared", 32'(match_count), 0);
    send_stream(16'b11, 2, 0);
    reset = 1; start = 1; bit_valid = 1; tick();
    reset = 0; start = 0; bit_valid = 0;
    chk("t4_rst_busy", 32'(busy), 0);
    chk("t4_rst_count", 32'(match_count), 0);
    pulse_start();
    send_stream(16'b110, 3, 0);
    chk("t4_default_done", 32'(done), 1);

    // Config ignored in RUN, len clamping, start+cfg together, restart mid-run
    cfg(8'b110, 3, 1, 0);
    pulse_start();
    cfg(8'b1, 1, 1, 0);
    send_stream(16'b1110, 4, 0);
    chk("t5_run_cfg_ignored", 32'(match_count), 1);
    pulse_stop();
    cfg(8'b1, 0, 1, 0);
    pulse_start();
    send_stream(16'b1011, 4, 1);
    chk("t5_len0", 32'(match_count), 3);
    pulse_stop();
    cfg_pattern = 8'hA5; cfg_len = 12; cfg_overlap = 1; cfg_threshold = 0;
    cfg_we = 1; start = 1; tick(); cfg_we = 0; start = 0;
    send_stream(16'h00A5, 8, 0);
    chk("t5_len12", 32'(match_count), 1);
    start = 1; bit_valid = 1; bit_in = 1; tick(); start = 0; bit_valid = 0;
    chk("t5_restart", 32'(match_count), 0);
    pulse_stop();

    // Saturation
    cfg(8'b1, 1, 1, 0);
    pulse_start();
    for (int i = 0; i < 20; i++) send(1, 0);
    chk("t6_count8", 32'(match_count), 20);
    chk("t6_count4", 32'(match_count4), 15);
    chk("t6_match4", 32'(match4), 1);
    pulse_stop();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit_valid     = ($urandom_range(0, 9) < 7);
      bit_in        = 1'($urandom_range(0, 1));
      start         = ($urandom_range(0, 99) < 4);
      stop          = ($urandom_range(0, 99) < 2);
      cfg_we        = ($urandom_range(0, 99) < 5);
      cfg_pattern   = 8'($urandom_range(0, 255));
      cfg_len       = 4'($urandom_range(0, 15));
      cfg_overlap   = 1'($urandom_range(0, 1));
      cfg_threshold = 8'($urandom_range(0, 6));
      reset         = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 0; start = 0; stop = 0; cfg_we = 0; bit_valid = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
